// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable asynchronous serial receiver.
//
// Frame format is fixed at elaboration time: PAYLOAD_BITS data bits (LSB first),
// optional odd/even parity, and 1 or 2 stop bits. Each bit is the majority vote
// of three samples taken around mid-bit. Parity, framing and break status are
// qualifiers that accompany the one-cycle valid pulse.
//
// Ports:
//   clk                 system clock, rising edge
//   resetn              asynchronous active-low reset
//   uart_rxd            asynchronous serial line, idles high
//   uart_rx_en          receive enable; dropping it mid-frame aborts the frame
//   uart_rx_valid       one-cycle pulse when a frame completes
//   uart_rx_data        received word, held until the next valid
//   uart_rx_parity_err  parity mismatch (only while valid)
//   uart_rx_frame_err   a stop bit sampled low (only while valid)
//   uart_rx_break       break condition (only while valid)
module uart_rx_cfg #(
  parameter int CLK_HZ       = 48000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0] SAMP_A    = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] SAMP_B    = CW'(CPB / 2);
  localparam logic [CW-1:0] SAMP_C    = CW'(CPB / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // [0],[1]: two-flop synchroniser; [2]: history flop for falling-edge detect.
  logic [2:0] rxd_pipe_reg;
  logic       rxd_s;
  logic       fall;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [BW-1:0]           bit_idx_reg, bit_idx_next;
  logic                    stop_idx_reg, stop_idx_next;
  logic                    samp_a_reg, samp_a_next;
  logic                    samp_b_reg, samp_b_next;
  logic [PAYLOAD_BITS-1:0] shift_reg, shift_next;
  logic                    par_bit_reg, par_bit_next;
  logic                    ferr_acc_reg, ferr_acc_next;
  logic                    first_stop_reg, first_stop_next;
  logic                    lock_reg, lock_next;
  logic                    valid_reg, valid_next;
  logic [PAYLOAD_BITS-1:0] data_reg, data_next;
  logic                    perr_reg, perr_next;
  logic                    ferr_reg, ferr_next;
  logic                    brk_reg, brk_next;

  logic vote;
  logic at_c;
  logic at_end;
  logic par_xor;
  logic parity_bad;
  logic first_stop_val;
  logic is_break;
  logic stop_ferr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_pipe_reg <= '1;
    end else begin
      rxd_pipe_reg <= {rxd_pipe_reg[1:0], uart_rxd};
    end
  end

  assign rxd_s = rxd_pipe_reg[1];
  assign fall  = rxd_pipe_reg[2] & ~rxd_s;

  // The third sample is the live synchronised line, so the vote is ready at SAMP_C.
  assign vote   = (samp_a_reg & samp_b_reg) | (samp_a_reg & rxd_s) | (samp_b_reg & rxd_s);
  assign at_c   = (cnt_reg == SAMP_C);
  assign at_end = (cnt_reg == CNT_LAST);

  assign par_xor    = (^shift_reg) ^ par_bit_reg;
  assign parity_bad = (PARITY == 1) ? ~par_xor : (PARITY == 2) ? par_xor : 1'b0;

  // With one stop bit the first stop is the one being voted right now.
  assign first_stop_val = (stop_idx_reg == 1'b0) ? vote : first_stop_reg;
  assign is_break  = (shift_reg == '0) && ((PARITY == 0) || !par_bit_reg) && !first_stop_val;
  assign stop_ferr = ferr_acc_reg | ~vote;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = (state_reg == S_IDLE || at_end) ? '0 : cnt_reg + 1'b1;
    bit_idx_next    = bit_idx_reg;
    stop_idx_next   = stop_idx_reg;
    samp_a_next     = (cnt_reg == SAMP_A) ? rxd_s : samp_a_reg;
    samp_b_next     = (cnt_reg == SAMP_B) ? rxd_s : samp_b_reg;
    shift_next      = shift_reg;
    par_bit_next    = par_bit_reg;
    ferr_acc_next   = ferr_acc_reg;
    first_stop_next = first_stop_reg;
    // Any high level on the line re-arms start detection after a break.
    lock_next       = rxd_s ? 1'b0 : lock_reg;
    valid_next      = 1'b0;
    data_next       = data_reg;
    perr_next       = 1'b0;
    ferr_next       = 1'b0;
    brk_next        = 1'b0;

    if (!uart_rx_en && state_reg != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
          ferr_acc_next = 1'b0;
          if (fall && uart_rx_en && !lock_reg) begin
            state_next = S_START;
            cnt_next   = '0;
          end
        end
        S_START: begin
          if (at_c && vote) begin
            state_next = S_IDLE;  // false start: glitch shorter than half a bit
          end else if (at_end) begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (at_c) begin
            shift_next = {vote, shift_reg[PAYLOAD_BITS-1:1]};
          end
          if (at_end) begin
            if (bit_idx_reg == DATA_LAST) begin
              state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_next = bit_idx_reg + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (at_c) begin
            par_bit_next = vote;
          end
          if (at_end) begin
            state_next = S_STOP;
          end
        end
        S_STOP: begin
          if (at_c) begin
            ferr_acc_next = stop_ferr;
            if (stop_idx_reg == 1'b0) begin
              first_stop_next = vote;
            end
            // Complete at the final sample point, not the bit end, so the
            // following start edge is caught even with zero idle time.
            if (stop_idx_reg == STOP_LAST) begin
              state_next = S_IDLE;
              valid_next = 1'b1;
              data_next  = shift_reg;
              perr_next  = parity_bad;
              ferr_next  = stop_ferr;
              brk_next   = is_break;
              if (is_break) begin
                lock_next = 1'b1;
              end
            end
          end else if (at_end) begin
            stop_idx_next = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      stop_idx_reg   <= 1'b0;
      samp_a_reg     <= 1'b1;
      samp_b_reg     <= 1'b1;
      shift_reg      <= '0;
      par_bit_reg    <= 1'b0;
      ferr_acc_reg   <= 1'b0;
      first_stop_reg <= 1'b1;
      lock_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      data_reg       <= '0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
      brk_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      stop_idx_reg   <= stop_idx_next;
      samp_a_reg     <= samp_a_next;
      samp_b_reg     <= samp_b_next;
      shift_reg      <= shift_next;
      par_bit_reg    <= par_bit_next;
      ferr_acc_reg   <= ferr_acc_next;
      first_stop_reg <= first_stop_next;
      lock_reg       <= lock_next;
      valid_reg      <= valid_next;
      data_reg       <= data_next;
      perr_reg       <= perr_next;
      ferr_reg       <= ferr_next;
      brk_reg        <= brk_next;
    end
  end

  assign uart_rx_valid      = valid_reg;
  assign uart_rx_data       = data_reg;
  assign uart_rx_parity_err = perr_reg;
  assign uart_rx_frame_err  = ferr_reg;
  assign uart_rx_break      = brk_reg;

endmodule
